// File: rtl/mul_op_sequencer_pkg.sv
// mul_seq_pkg: shared constants and types for the multiplier operand sequencer.
//   OPW / PW      operand and product widths of the 4x4 shift-add core
//   state_t       sequencer FSM states
//   res_t         registered result word (product, tag, error flag)
//   make_res      builds a res_t from its fields
package mul_seq_pkg;

  localparam int OPW       = 4;
  localparam int PW        = 8;
  // Widest tag the result word can carry; instantiations keep TAG_W <= this.
  localparam int TAG_MAX_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    GUARD_W = 2'd2,
    WAIT    = 2'd3
  } state_t;

  typedef struct packed {
    logic [PW-1:0]        p;
    logic [TAG_MAX_W-1:0] tag;
    logic                 err;
  } res_t;

  function automatic res_t make_res(input logic [PW-1:0] p,
                                    input logic [TAG_MAX_W-1:0] tag,
                                    input logic err);
    res_t r;
    r.p   = p;
    r.tag = tag;
    r.err = err;
    return r;
  endfunction

endpackage

// File: rtl/mul_op_fifo.sv
// mul_op_fifo: small synchronous FIFO holding queued operand pairs + tags.
//   CK, RN        clock (rising edge), asynchronous active-low reset
//   push, pop     write / read strobes; ignored when full / empty
//   wdata, rdata  entry in, head entry out (rdata is the current head)
//   count         number of stored entries
//   full, empty   derived from count
module mul_op_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 2
) (
  input  logic                           CK,
  input  logic                           RN,
  input  logic                           push,
  input  logic                           pop,
  input  logic [W-1:0]                   wdata,
  output logic [W-1:0]                   rdata,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mul_op_sequencer.sv
// mul_op_sequencer: feeds a 4x4 shift-add multiplier core from a queued
// operand stream and returns tagged products on a result stream.
//   CK, RN                     clock (rising), asynchronous active-low reset
//   OP_VALID/OP_READY          operand stream handshake
//   OP_A, OP_B, OP_TAG         multiplicand, multiplier, request tag
//   MUL_A, MUL_B, MUL_START    operands and start pulse to the core
//   MUL_P, MUL_READY           product and ready from the core
//   RES_VALID/RES_READY        result stream handshake
//   RES_P, RES_TAG, RES_ERR    product, its tag, timeout flag (RES_P=0 then)
//   BUSY                       an op is in flight or operands are queued
module mul_op_sequencer
  import mul_seq_pkg::*;
#(
  parameter int TAG_W      = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int GUARD      = 1,
  parameter int TIMEOUT    = 16
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             OP_VALID,
  output logic             OP_READY,
  input  logic [3:0]       OP_A,
  input  logic [3:0]       OP_B,
  input  logic [TAG_W-1:0] OP_TAG,
  output logic [3:0]       MUL_A,
  output logic [3:0]       MUL_B,
  output logic             MUL_START,
  input  logic [7:0]       MUL_P,
  input  logic             MUL_READY,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [7:0]       RES_P,
  output logic [TAG_W-1:0] RES_TAG,
  output logic             RES_ERR,
  output logic             BUSY
);

  localparam int FW = 2*OPW + TAG_W;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

  state_t           state_q, state_d;
  logic [OPW-1:0]   mul_a_d, mul_b_d;
  logic             start_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  res_t             res_q, res_d;
  logic             res_valid_d;
  logic             busy_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [GW-1:0]    guard_q, guard_d;
  logic             live_q;

  logic             push;
  logic             launch;
  logic [FW-1:0]    fifo_rdata;
  logic [CW-1:0]    fifo_count;
  logic [CW-1:0]    count_d;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OPW-1:0]   head_a, head_b;
  logic [TAG_W-1:0] head_tag;

  // live_q keeps OP_READY low while RN is asserted; the FIFO count alone
  // would already read "not full" during reset.
  assign OP_READY = live_q & ~fifo_full;
  assign push     = OP_VALID & OP_READY;
  // A new op may start only once the result slot is empty or being drained.
  assign launch   = (state_q == IDLE) & ~fifo_empty & (~RES_VALID | RES_READY);

  assign {head_a, head_b, head_tag} = fifo_rdata;

  assign RES_P   = res_q.p;
  assign RES_TAG = TAG_W'(res_q.tag);
  assign RES_ERR = res_q.err;

  mul_op_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CK    (CK),
    .RN    (RN),
    .push  (push),
    .pop   (launch),
    .wdata ({OP_A, OP_B, OP_TAG}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State and registered outputs
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q   <= IDLE;
      MUL_A     <= '0;
      MUL_B     <= '0;
      MUL_START <= 1'b0;
      tag_q     <= '0;
      res_q     <= '0;
      RES_VALID <= 1'b0;
      BUSY      <= 1'b0;
      timer_q   <= '0;
      guard_q   <= '0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      MUL_A     <= mul_a_d;
      MUL_B     <= mul_b_d;
      MUL_START <= start_d;
      tag_q     <= tag_d;
      res_q     <= res_d;
      RES_VALID <= res_valid_d;
      BUSY      <= busy_d;
      timer_q   <= timer_d;
      guard_q   <= guard_d;
      live_q    <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = LAUNCH;
      LAUNCH:  state_d = GUARD_W;
      GUARD_W: if (guard_q == GW'(GUARD - 1)) state_d = WAIT;
      WAIT:    if (MUL_READY || (timer_q == TW'(TIMEOUT - 1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    mul_a_d     = MUL_A;
    mul_b_d     = MUL_B;
    start_d     = 1'b0;
    tag_d       = tag_q;
    res_d       = res_q;
    res_valid_d = RES_VALID & ~RES_READY;
    timer_d     = timer_q;
    guard_d     = guard_q;

    case (state_q)
      IDLE: begin
        if (launch) begin
          mul_a_d = head_a;
          mul_b_d = head_b;
          tag_d   = head_tag;
          start_d = 1'b1;
        end
      end
      LAUNCH: begin
        guard_d = '0;
      end
      GUARD_W: begin
        // The core is still dropping READY from its previous op here.
        guard_d = guard_q + GW'(1);
        timer_d = '0;
      end
      WAIT: begin
        if (MUL_READY) begin
          res_d       = make_res(MUL_P, TAG_MAX_W'(tag_q), 1'b0);
          res_valid_d = 1'b1;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          res_d       = make_res('0, TAG_MAX_W'(tag_q), 1'b1);
          res_valid_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: ;
    endcase
  end

  // FIFO occupancy after this edge, so BUSY can be registered
  always_comb begin
    count_d = fifo_count;
    if (push && !launch) begin
      count_d = fifo_count + CW'(1);
    end else if (!push && launch) begin
      count_d = fifo_count - CW'(1);
    end
    busy_d = (state_d != IDLE) || (count_d != '0);
  end

endmodule

// File: tb/tb_mul_op_sequencer.sv
module tb_mul_op_sequencer;

  localparam int TAG_W      = 2;
  localparam int FIFO_DEPTH = 2;
  localparam int GUARD      = 1;
  localparam int TIMEOUT    = 16;

  logic             CK = 1'b0;
  logic             RN = 1'b0;
  logic             OP_VALID = 1'b0;
  logic             OP_READY;
  logic [3:0]       OP_A = '0;
  logic [3:0]       OP_B = '0;
  logic [TAG_W-1:0] OP_TAG = '0;
  logic [3:0]       MUL_A;
  logic [3:0]       MUL_B;
  logic             MUL_START;
  logic [7:0]       MUL_P;
  logic             MUL_READY;
  logic             RES_VALID;
  logic             RES_READY = 1'b0;
  logic [7:0]       RES_P;
  logic [TAG_W-1:0] RES_TAG;
  logic             RES_ERR;
  logic             BUSY;

  int total = 0;
  int bad   = 0;

  always #5 CK = ~CK;

  mul_op_sequencer #(
    .TAG_W      (TAG_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .GUARD      (GUARD),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .CK        (CK),
    .RN        (RN),
    .OP_VALID  (OP_VALID),
    .OP_READY  (OP_READY),
    .OP_A      (OP_A),
    .OP_B      (OP_B),
    .OP_TAG    (OP_TAG),
    .MUL_A     (MUL_A),
    .MUL_B     (MUL_B),
    .MUL_START (MUL_START),
    .MUL_P     (MUL_P),
    .MUL_READY (MUL_READY),
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY),
    .RES_P     (RES_P),
    .RES_TAG   (RES_TAG),
    .RES_ERR   (RES_ERR),
    .BUSY      (BUSY)
  );

  // Core model: drops READY on START, raises it with the product 4 cycles
  // later; with hang set it never comes back.
  logic [3:0] core_a = '0;
  logic [3:0] core_b = '0;
  logic [7:0] core_p;
  logic       core_rdy;
  int         core_cnt;
  logic       hang = 1'b0;
  int         start_cnt = 0;

  assign MUL_READY = core_rdy;
  assign MUL_P     = core_p;

  always @(posedge CK or negedge RN) begin
    if (!RN) begin
      core_rdy <= 1'b1;
      core_cnt <= 0;
      core_p   <= '0;
    end else if (MUL_START) begin
      core_rdy <= 1'b0;
      core_a   <= MUL_A;
      core_b   <= MUL_B;
      core_cnt <= hang ? 0 : 4;
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end else if (core_cnt == 1) begin
      core_rdy <= 1'b1;
      core_p   <= 8'(core_a) * 8'(core_b);
      core_cnt <= 0;
    end
  end

  always @(posedge CK) begin
    if (MUL_START) start_cnt <= start_cnt + 1;
  end

  logic [7:0]       got_p[$];
  logic [TAG_W-1:0] got_tag[$];
  logic             got_err[$];

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b,
                      input logic [TAG_W-1:0] t);
    bit rs;
    bit ok;
    ok       = 1'b0;
    OP_A     = a;
    OP_B     = b;
    OP_TAG   = t;
    OP_VALID = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rs = OP_READY;
      tick();
      if (rs) begin
        ok = 1'b1;
        break;
      end
    end
    OP_VALID = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL push_timeout a=%0d b=%0d: OP_READY never 1", a, b);
    end
  endtask

  task automatic collect(input int n, input int budget);
    for (int i = 0; i < budget && got_p.size() < n; i++) begin
      if (RES_VALID && RES_READY) begin
        got_p.push_back(RES_P);
        got_tag.push_back(RES_TAG);
        got_err.push_back(RES_ERR);
      end
      tick();
    end
    if (got_p.size() < n) begin
      total++;
      bad++;
      $display("FAIL collect_timeout got=%0d want=%0d", got_p.size(), n);
    end
  endtask

  task automatic test_reset();
    RN = 1'b0;
    tick();
    tick();
    total++; if (OP_READY !== 1'b0) begin bad++; $display("FAIL rst_op_ready got=%0b exp=0", OP_READY); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", BUSY); end
    total++; if (RES_VALID !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%0b exp=0", RES_VALID); end
    total++; if (MUL_START !== 1'b0) begin bad++; $display("FAIL rst_start got=%0b exp=0", MUL_START); end
    total++; if (RES_P !== 8'd0 || MUL_A !== 4'd0) begin bad++; $display("FAIL rst_data res_p=%0d mul_a=%0d exp=0", RES_P, MUL_A); end
    RN = 1'b1;
    tick();
    tick();
    total++; if (OP_READY !== 1'b1) begin bad++; $display("FAIL rst_release_op_ready got=%0b exp=1", OP_READY); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_release_busy got=%0b exp=0", BUSY); end
  endtask

  task automatic test_single();
    int s0;
    bit stable_bad;
    bit seen;
    stable_bad = 1'b0;
    seen       = 1'b0;
    RES_READY  = 1'b0;
    s0         = start_cnt;
    push(4'd3, 4'd5, 2'd1);
    for (int i = 0; i < 40; i++) begin
      if (RES_VALID) begin
        seen = 1'b1;
        break;
      end
      if (start_cnt != s0 && (MUL_A !== 4'd3 || MUL_B !== 4'd5)) stable_bad = 1'b1;
      tick();
    end
    total++; if (!seen) begin bad++; $display("FAIL single_valid got=0 exp=1"); end
    total++; if (RES_P !== 8'd15) begin bad++; $display("FAIL single_p got=%0d exp=15", RES_P); end
    total++; if (RES_TAG !== 2'd1) begin bad++; $display("FAIL single_tag got=%0d exp=1", RES_TAG); end
    total++; if (RES_ERR !== 1'b0) begin bad++; $display("FAIL single_err got=%0b exp=0", RES_ERR); end
    total++; if (stable_bad) begin bad++; $display("FAIL single_operands_stable got=changed exp=3x5"); end
    tick();
    tick();
    tick();
    total++; if (RES_VALID !== 1'b1 || RES_P !== 8'd15) begin bad++; $display("FAIL single_hold valid=%0b p=%0d exp 1/15", RES_VALID, RES_P); end
    total++; if (start_cnt - s0 != 1) begin bad++; $display("FAIL single_start_count got=%0d exp=1", start_cnt - s0); end
    RES_READY = 1'b1;
    tick();
    RES_READY = 1'b0;
    total++; if (RES_VALID !== 1'b0) begin bad++; $display("FAIL single_accept valid got=%0b exp=0", RES_VALID); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL single_busy got=%0b exp=0", BUSY); end
  endtask

  task automatic test_back_to_back();
    got_p.delete(); got_tag.delete(); got_err.delete();
    RES_READY = 1'b1;
    push(4'd15, 4'd15, 2'd2);
    push(4'd0, 4'd9, 2'd3);
    collect(2, 80);
    total++; if (got_p[0] !== 8'd225 || got_tag[0] !== 2'd2 || got_err[0] !== 1'b0) begin
      bad++; $display("FAIL b2b_first p=%0d tag=%0d err=%0b exp 225/2/0", got_p[0], got_tag[0], got_err[0]);
    end
    total++; if (got_p[1] !== 8'd0 || got_tag[1] !== 2'd3 || got_err[1] !== 1'b0) begin
      bad++; $display("FAIL b2b_second p=%0d tag=%0d err=%0b exp 0/3/0", got_p[1], got_tag[1], got_err[1]);
    end
    RES_READY = 1'b0;
  endtask

  task automatic test_backpressure();
    int s0;
    bit seen;
    bit hold_bad;
    bit ready_bad;
    seen      = 1'b0;
    hold_bad  = 1'b0;
    ready_bad = 1'b0;
    got_p.delete(); got_tag.delete(); got_err.delete();
    RES_READY = 1'b0;
    s0        = start_cnt;
    push(4'd2, 4'd3, 2'd0);
    push(4'd4, 4'd5, 2'd1);
    push(4'd6, 4'd7, 2'd2);
    total++; if (OP_READY !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%0b exp=0", OP_READY); end
    OP_A = 4'd1; OP_B = 4'd1; OP_TAG = 2'd3; OP_VALID = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (OP_READY) ready_bad = 1'b1;
      if (RES_VALID) seen = 1'b1;
      if (seen && (RES_VALID !== 1'b1 || RES_P !== 8'd6 || RES_TAG !== 2'd0)) hold_bad = 1'b1;
      tick();
    end
    total++; if (!seen) begin bad++; $display("FAIL bp_first_valid got=0 exp=1"); end
    total++; if (hold_bad) begin bad++; $display("FAIL bp_hold got=unstable exp=6 tag0 held"); end
    total++; if (ready_bad) begin bad++; $display("FAIL bp_op_ready_while_full got=1 exp=0"); end
    total++; if (start_cnt - s0 != 1) begin bad++; $display("FAIL bp_single_start got=%0d exp=1", start_cnt - s0); end
    // Pop and push requested on the same edge with the FIFO full
    RES_READY = 1'b1;
    tick();
    total++; if (OP_READY !== 1'b1) begin bad++; $display("FAIL full_pop_push_rejected op_ready got=%0b exp=1", OP_READY); end
    total++; if (RES_VALID !== 1'b0) begin bad++; $display("FAIL full_pop_res_valid got=%0b exp=0", RES_VALID); end
    tick();
    total++; if (OP_READY !== 1'b0) begin bad++; $display("FAIL full_push_next_cycle op_ready got=%0b exp=0", OP_READY); end
    OP_VALID = 1'b0;
    collect(3, 120);
    total++; if (got_p[0] !== 8'd20 || got_tag[0] !== 2'd1) begin bad++; $display("FAIL bp_res1 p=%0d tag=%0d exp 20/1", got_p[0], got_tag[0]); end
    total++; if (got_p[1] !== 8'd42 || got_tag[1] !== 2'd2) begin bad++; $display("FAIL bp_res2 p=%0d tag=%0d exp 42/2", got_p[1], got_tag[1]); end
    total++; if (got_p[2] !== 8'd1 || got_tag[2] !== 2'd3) begin bad++; $display("FAIL bp_res3 p=%0d tag=%0d exp 1/3", got_p[2], got_tag[2]); end
    RES_READY = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    got_p.delete(); got_tag.delete(); got_err.delete();
    RES_READY = 1'b1;
    hang      = 1'b1;
    push(4'd5, 4'd5, 2'd1);
    push(4'd3, 4'd4, 2'd2);
    for (int i = 0; i < 10 && !MUL_START; i++) tick();
    n = 0;
    while (!RES_VALID && n < 60) begin
      tick();
      n++;
      if (n == 1) hang = 1'b0;
    end
    total++; if (n != 1 + GUARD + TIMEOUT) begin bad++; $display("FAIL timeout_latency got=%0d exp=%0d", n, 1 + GUARD + TIMEOUT); end
    total++; if (RES_ERR !== 1'b1 || RES_P !== 8'd0) begin bad++; $display("FAIL timeout_result err=%0b p=%0d exp 1/0", RES_ERR, RES_P); end
    collect(2, 80);
    total++; if (got_p[1] !== 8'd12 || got_err[1] !== 1'b0 || got_tag[1] !== 2'd2) begin
      bad++; $display("FAIL timeout_next_op p=%0d err=%0b tag=%0d exp 12/0/2", got_p[1], got_err[1], got_tag[1]);
    end
    RES_READY = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit stale;
    stale = 1'b0;
    got_p.delete(); got_tag.delete(); got_err.delete();
    RES_READY = 1'b1;
    hang      = 1'b1;
    push(4'd9, 4'd9, 2'd0);
    push(4'd2, 4'd2, 2'd1);
    for (int i = 0; i < 6; i++) tick();
    hang = 1'b0;
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%0b exp=1", BUSY); end
    RN = 1'b0;
    #1;
    total++; if (MUL_START !== 1'b0 || RES_VALID !== 1'b0) begin bad++; $display("FAIL mid_rst_async start=%0b valid=%0b exp 0/0", MUL_START, RES_VALID); end
    total++; if (OP_READY !== 1'b0 || BUSY !== 1'b0) begin bad++; $display("FAIL mid_rst_async op_ready=%0b busy=%0b exp 0/0", OP_READY, BUSY); end
    tick();
    tick();
    RN = 1'b1;
    tick();
    tick();
    total++; if (OP_READY !== 1'b1) begin bad++; $display("FAIL mid_release_op_ready got=%0b exp=1", OP_READY); end
    for (int i = 0; i < 12; i++) begin
      if (RES_VALID || MUL_START || BUSY) stale = 1'b1;
      tick();
    end
    total++; if (stale) begin bad++; $display("FAIL mid_stale_activity got=activity exp=none"); end
    push(4'd7, 4'd6, 2'd2);
    collect(1, 60);
    total++; if (got_p[0] !== 8'd42 || got_tag[0] !== 2'd2 || got_err[0] !== 1'b0) begin
      bad++; $display("FAIL mid_new_op p=%0d tag=%0d err=%0b exp 42/2/0", got_p[0], got_tag[0], got_err[0]);
    end
    RES_READY = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
